// File: rtl/leds_racer_pkg.sv
// LED racer shared definitions.
// State encodings, width helpers and default parameter values.
package leds_racer_pkg;

  typedef enum logic [1:0] {
    ST_MENU = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_BAD  = 2'd3
  } state_e;

  localparam int DEF_N_PLAYERS       = 4;
  localparam int DEF_LED_COUNT       = 64;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/leds_racer_debouncer.sv
// Per-button synchroniser, debounce counter and rise pulse.
// A button held through reset must be seen released before it can fire.
module leds_racer_debouncer
  import leds_racer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = max1(clog2(DEBOUNCE_CYCLES + 1));
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [1:0]    r_vld;
  logic          r_armed;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_rise;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= '0;
      r_vld   <= '0;
      r_armed <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_vld  <= {r_vld[0], 1'b1};
      r_rise <= 1'b0;
      // Until armed, count a settled low run on real synchroniser samples.
      if (!r_armed) begin
        if (r_vld[1] && !r_sync[1]) begin
          if (r_cnt == CNT_LAST) begin
            r_armed <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end else if (r_sync[1] != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync[1];
          r_rise  <= r_sync[1];
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/leds_racer_game_core.sv
// LED racer game core: debounced inputs, race FSM, positions,
// winner selection and coalesced frame requests.
module leds_racer_game_core
  import leds_racer_pkg::*;
#(
  parameter int N_PLAYERS       = DEF_N_PLAYERS,
  parameter int LED_COUNT       = DEF_LED_COUNT,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  localparam int POS_W          = clog2(LED_COUNT),
  localparam int PID_W          = max1(clog2(N_PLAYERS))
) (
  input  logic                         CLK,
  input  logic                         FORCE_RESET,
  input  logic [N_PLAYERS-1:0]         BTN,
  input  logic                         FRAME_BUSY,
  output logic [N_PLAYERS*POS_W-1:0]   POSITIONS,
  output logic [1:0]                   GAME_STATE,
  output logic                         WINNER_VALID,
  output logic [PID_W-1:0]             WINNER_ID,
  output logic                         UPDATE_FRAME,
  output logic [N_PLAYERS-1:0]         PLAYER_RTP
);

  localparam logic [POS_W-1:0] POS_MAX = POS_W'(LED_COUNT - 1);

  logic [N_PLAYERS-1:0] w_level;
  logic [N_PLAYERS-1:0] w_press;

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_db
    leds_racer_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .i_clk  (CLK),
      .i_rst  (FORCE_RESET),
      .i_btn  (BTN[g]),
      .o_level(w_level[g]),
      .o_rise (w_press[g])
    );
  end

  state_e           r_state;
  logic [POS_W-1:0] r_pos [N_PLAYERS];
  logic [PID_W-1:0] r_wid;
  logic             r_rel;
  logic             r_pend;
  logic             r_upd;

  state_e           w_nstate;
  logic [POS_W-1:0] w_npos [N_PLAYERS];
  logic [PID_W-1:0] w_nwid;
  logic             w_nrel;
  logic             w_hit;
  logic [PID_W-1:0] w_hit_id;
  logic             w_change;
  logic [N_PLAYERS*POS_W-1:0] w_pos_flat;

  always_comb begin
    w_nstate = r_state;
    w_npos   = r_pos;
    w_nwid   = r_wid;
    w_nrel   = r_rel;
    w_hit    = 1'b0;
    w_hit_id = '0;
    // Descending scan leaves the lowest finishing index.
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (r_pos[i] == POS_MAX) begin
        w_hit    = 1'b1;
        w_hit_id = PID_W'(i);
      end
    end
    case (r_state)
      ST_MENU: begin
        if (|w_press) w_nstate = ST_PLAY;
      end
      ST_PLAY: begin
        for (int i = 0; i < N_PLAYERS; i++) begin
          if (w_press[i] && r_pos[i] != POS_MAX)
            w_npos[i] = r_pos[i] + 1'b1;
        end
        if (w_hit) begin
          w_nstate = ST_WIN;
          w_nwid   = w_hit_id;
          w_nrel   = 1'b0;
        end
      end
      ST_WIN: begin
        if (!r_rel) begin
          w_nrel = ~|w_level;
        end else if (|w_press) begin
          w_nstate = ST_MENU;
          w_nwid   = '0;
          for (int i = 0; i < N_PLAYERS; i++) w_npos[i] = '0;
        end
      end
      default: w_nstate = ST_MENU;
    endcase
  end

  always_comb begin
    w_change = (w_nstate != r_state);
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (w_npos[i] != r_pos[i]) w_change = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (FORCE_RESET) begin
      r_state <= ST_MENU;
      for (int i = 0; i < N_PLAYERS; i++) r_pos[i] <= '0;
      r_wid  <= '0;
      r_rel  <= 1'b0;
      r_pend <= 1'b1;
      r_upd  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_pos   <= w_npos;
      r_wid   <= w_nwid;
      r_rel   <= w_nrel;
      r_upd   <= r_pend & ~FRAME_BUSY;
      r_pend  <= w_change | (r_pend & FRAME_BUSY);
    end
  end

  always_comb begin
    w_pos_flat = '0;
    for (int i = 0; i < N_PLAYERS; i++)
      w_pos_flat[i*POS_W +: POS_W] = r_pos[i];
  end

  assign POSITIONS    = w_pos_flat;
  assign GAME_STATE   = r_state;
  assign WINNER_VALID = (r_state == ST_WIN);
  assign WINNER_ID    = r_wid;
  assign UPDATE_FRAME = r_upd;
  assign PLAYER_RTP   = w_press;

endmodule

// File: tb/tb_leds_racer_game_core.sv
// Bench for leds_racer_game_core: directed table, corner sequences,
// and randomized presses against a game-rule reference model.
module tb_leds_racer_game_core;

  localparam int NP = 4;
  localparam int LC = 8;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy = 1'b0;
  logic [3:0]  btn = 4'b0;
  logic [11:0] positions;
  logic [1:0]  game_state;
  logic        winner_valid;
  logic [1:0]  winner_id;
  logic        update_frame;
  logic [3:0]  player_rtp;

  leds_racer_game_core #(
    .N_PLAYERS(NP),
    .LED_COUNT(LC),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .CLK         (clk),
    .FORCE_RESET (rst),
    .BTN         (btn),
    .FRAME_BUSY  (busy),
    .POSITIONS   (positions),
    .GAME_STATE  (game_state),
    .WINNER_VALID(winner_valid),
    .WINNER_ID   (winner_id),
    .UPDATE_FRAME(update_frame),
    .PLAYER_RTP  (player_rtp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int frame_cnt = 0;
  int rtp_cnt [4] = '{0, 0, 0, 0};
  int f0;
  int r0 [4];

  always @(negedge clk) begin
    if (update_frame === 1'b1) frame_cnt++;
    for (int i = 0; i < 4; i++)
      if (player_rtp[i] === 1'b1) rtp_cnt[i]++;
  end

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [11:0] pk(input int a, input int b,
                                     input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  task automatic snap();
    f0 = frame_cnt;
    for (int i = 0; i < 4; i++) r0[i] = rtp_cnt[i];
  endtask

  function automatic logic [15:0] rtp_delta();
    logic [15:0] d;
    for (int i = 0; i < 4; i++) d[i*4 +: 4] = 4'(rtp_cnt[i] - r0[i]);
    return d;
  endfunction

  function automatic logic [15:0] rtp_exp(input logic [3:0] m);
    logic [15:0] d;
    for (int i = 0; i < 4; i++) d[i*4 +: 4] = m[i] ? 4'd1 : 4'd0;
    return d;
  endfunction

  task automatic press(input logic [3:0] m, input int hold, input int gap);
    @(negedge clk);
    btn = m;
    repeat (hold) @(negedge clk);
    btn = 4'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic [1:0]  st;
    logic [11:0] pos;
    logic        wv;
    logic [1:0]  wid;
    int          fr;
  } vec_t;

  vec_t tbl [11];

  int m_st;
  int m_pos [4];
  int m_wid;
  int m_fr;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    int p1;
    int hold;
    int gap;
    int pid;

    tbl[0]  = '{4'b0001, 2'd1, pk(0, 0, 0, 0), 1'b0, 2'd0, 1};
    tbl[1]  = '{4'b0100, 2'd1, pk(0, 0, 1, 0), 1'b0, 2'd0, 1};
    tbl[2]  = '{4'b0100, 2'd1, pk(0, 0, 2, 0), 1'b0, 2'd0, 1};
    tbl[3]  = '{4'b0100, 2'd1, pk(0, 0, 3, 0), 1'b0, 2'd0, 1};
    tbl[4]  = '{4'b1010, 2'd1, pk(0, 1, 3, 1), 1'b0, 2'd0, 1};
    tbl[5]  = '{4'b1010, 2'd1, pk(0, 2, 3, 2), 1'b0, 2'd0, 1};
    tbl[6]  = '{4'b1010, 2'd1, pk(0, 3, 3, 3), 1'b0, 2'd0, 1};
    tbl[7]  = '{4'b1010, 2'd1, pk(0, 4, 3, 4), 1'b0, 2'd0, 1};
    tbl[8]  = '{4'b1010, 2'd1, pk(0, 5, 3, 5), 1'b0, 2'd0, 1};
    tbl[9]  = '{4'b1010, 2'd1, pk(0, 6, 3, 6), 1'b0, 2'd0, 1};
    tbl[10] = '{4'b0001, 2'd1, pk(0, 6, 3, 6), 1'b0, 2'd0, 0};

    // Reset then idle: a single frame request, everything cleared.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    snap();
    repeat (12) @(negedge clk);
    check("rst_frames", frame_cnt - f0, 1);
    check("rst_state", game_state, 0);
    check("rst_pos", positions, 0);
    check("rst_wv", winner_valid, 0);
    check("rst_wid", winner_id, 0);
    check("rst_rtp", rtp_delta(), 0);

    // Directed table; last entry is a press of an idle player in PLAY.
    for (int k = 0; k < 11; k++) begin
      snap();
      press(tbl[k].mask, 8, 12);
      check($sformatf("tbl%0d_state", k), game_state, tbl[k].st);
      check($sformatf("tbl%0d_pos", k), positions,
            (k == 10) ? pk(1, 6, 3, 6) : tbl[k].pos);
      check($sformatf("tbl%0d_wv", k), winner_valid, tbl[k].wv);
      check($sformatf("tbl%0d_wid", k), winner_id, tbl[k].wid);
      check($sformatf("tbl%0d_fr", k), frame_cnt - f0,
            (k == 10) ? 1 : tbl[k].fr);
      check($sformatf("tbl%0d_rtp", k), rtp_delta(), rtp_exp(tbl[k].mask));
    end

    // Players 1 and 3 finish together; lowest index wins, held keys block.
    @(negedge clk);
    btn = 4'b1010;
    repeat (20) @(negedge clk);
    check("win_state", game_state, 2);
    check("win_wv", winner_valid, 1);
    check("win_id", winner_id, 1);
    check("win_pos", positions, pk(1, 7, 3, 7));
    btn = 4'b1011;
    repeat (12) @(negedge clk);
    btn = 4'b1010;
    repeat (12) @(negedge clk);
    check("win_ign_state", game_state, 2);
    check("win_ign_pos", positions, pk(1, 7, 3, 7));
    btn = 4'b0;
    repeat (15) @(negedge clk);
    snap();
    press(4'b0001, 8, 12);
    check("win_exit_state", game_state, 0);
    check("win_exit_pos", positions, 0);
    check("win_exit_wv", winner_valid, 0);
    check("win_exit_wid", winner_id, 0);
    check("win_exit_fr", frame_cnt - f0, 1);

    press(4'b0001, 8, 12);
    check("play2_state", game_state, 1);

    // Fixed latency: the 7th edge after the raw rise moves the position.
    @(negedge clk);
    btn = 4'b0100;
    p0 = -1;
    p1 = -1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (e == 3 + DB - 1) p0 = int'(positions[8:6]);
      if (e == 3 + DB) p1 = int'(positions[8:6]);
    end
    @(negedge clk);
    btn = 4'b0;
    repeat (12) @(negedge clk);
    check("lat_before", p0, 0);
    check("lat_at", p1, 1);

    // Bounce: toggling every 2 cycles never settles long enough.
    snap();
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      btn[1] = ((t / 2) % 2 == 0);
    end
    btn = 4'b0;
    repeat (12) @(negedge clk);
    check("bounce_rtp", rtp_delta(), 0);
    check("bounce_pos", positions, pk(0, 0, 1, 0));

    // Busy frame driver: changes coalesce into one request.
    @(negedge clk);
    busy = 1'b1;
    snap();
    for (int k = 0; k < 3; k++) press(4'b0100, 8, 12);
    check("busy_fr_held", frame_cnt - f0, 0);
    check("busy_pos", positions, pk(0, 0, 4, 0));
    busy = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_fr_release", frame_cnt - f0, 1);

    // Reset during WIN with a held button.
    for (int k = 0; k < 7; k++) press(4'b0001, 8, 12);
    check("rw_state", game_state, 2);
    check("rw_wid", winner_id, 0);
    snap();
    @(negedge clk);
    btn = 4'b0001;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rw_menu", game_state, 0);
    check("rw_pos", positions, 0);
    check("rw_wv", winner_valid, 0);
    check("rw_held_rtp", rtp_delta(), 0);
    btn = 4'b0;
    repeat (15) @(negedge clk);
    snap();
    press(4'b0001, 8, 12);
    check("rw_repress_state", game_state, 1);
    check("rw_repress_rtp", rtp_delta(), rtp_exp(4'b0001));

    // Randomized single-player presses against the game rules.
    do_reset();
    repeat (14) @(negedge clk);
    m_st = 0;
    m_wid = 0;
    for (int i = 0; i < 4; i++) m_pos[i] = 0;
    for (int k = 0; k < 40; k++) begin
      pid = $urandom_range(0, 3);
      hold = $urandom_range(6, 10);
      gap = $urandom_range(10, 14);
      snap();
      press(4'(1 << pid), hold, gap);
      if (m_st == 0) begin
        m_st = 1;
        m_fr = 1;
      end else if (m_st == 1) begin
        m_pos[pid] = (m_pos[pid] < LC - 1) ? m_pos[pid] + 1 : LC - 1;
        m_fr = 1;
        if (m_pos[pid] == LC - 1) begin
          m_st = 2;
          m_wid = pid;
          m_fr = 2;
        end
      end else begin
        m_st = 0;
        m_wid = 0;
        for (int i = 0; i < 4; i++) m_pos[i] = 0;
        m_fr = 1;
      end
      check($sformatf("rnd%0d_state", k), game_state, m_st);
      check($sformatf("rnd%0d_pos", k), positions,
            pk(m_pos[0], m_pos[1], m_pos[2], m_pos[3]));
      check($sformatf("rnd%0d_wv", k), winner_valid, (m_st == 2));
      check($sformatf("rnd%0d_wid", k), winner_id, m_wid);
      check($sformatf("rnd%0d_fr", k), frame_cnt - f0, m_fr);
      check($sformatf("rnd%0d_rtp", k), rtp_delta(), rtp_exp(4'(1 << pid)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
